// File: rtl/note_recorder_if.sv
// Bus bundle between the note recorder and whoever drives it: record
// controls, live key input, sheet read port and status outputs.
interface note_recorder_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          rec_en;
  logic          clear;
  logic [4:0]    key_note;
  logic [AW-1:0] rd_addr;
  logic [4:0]    rd_note;
  logic [3:0]    rd_beats;
  logic [AW:0]   count;
  logic          full;
  logic          recording;
  logic [7:0]    led;

  modport master (
    output rec_en, clear, key_note, rd_addr,
    input  rd_note, rd_beats, count, full, recording, led
  );

  modport slave (
    input  rec_en, clear, key_note, rd_addr,
    output rd_note, rd_beats, count, full, recording, led
  );
endinterface

// File: rtl/note_recorder.sv
// Live note recorder: debounces the keyboard note code, measures how long each
// note (or rest) is held in beats, and stores {note, beats} entries in a small
// sheet memory that the auto player reads back through a synchronous port.
module note_recorder #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BEAT_CYC  = CLK_FREQ / 4,
  parameter int DEBOUNCE  = CLK_FREQ / 100,
  parameter int DEPTH     = 64,
  parameter int MAX_BEATS = 15
) (
  input logic            clk,
  input logic            rst,
  note_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYC - 1);
  localparam logic [CW-1:0] HALF_BEAT = CW'(BEAT_CYC / 2);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [3:0]    MAXB      = 4'(MAX_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REC, S_FULL} state_t;

  state_t        state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [DW-1:0] stab_cnt_q, stab_cnt_d;
  logic [4:0]    stable_q, stable_d;
  logic [4:0]    cur_q, cur_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    beats_q, beats_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          recording_q, recording_d;
  logic [7:0]    led_q, led_d;
  logic [4:0]    rd_note_q;
  logic [3:0]    rd_beats_q;

  logic [8:0]    mem [DEPTH];

  logic          commit_req;
  logic [3:0]    commit_len;
  logic          we;
  logic [8:0]    wdata;
  logic [3:0]    len;
  logic          split;
  logic [4:0]    cur_m1;
  logic [2:0]    led_idx;

  // Debounce, beat counting, commit decisions and status outputs.
  always_comb begin
    cand_d      = bus.key_note;
    stab_cnt_d  = stab_cnt_q;
    stable_d    = stable_q;
    state_d     = state_q;
    cur_d       = cur_q;
    cyc_d       = cyc_q;
    beats_d     = beats_q;
    count_d     = count_q;
    commit_req  = 1'b0;
    commit_len  = 4'd0;
    we          = 1'b0;
    wdata       = {cur_q, 4'd0};

    // A note only becomes "stable" after holding for DEBOUNCE cycles; press
    // and release see the same delay so segment lengths are not skewed.
    if (bus.key_note != cand_q)  stab_cnt_d = '0;
    else if (stab_cnt_q != DB_LAST) stab_cnt_d = stab_cnt_q + 1'b1;
    if (stab_cnt_q == DB_LAST) stable_d = cand_q;

    // Segment length rounded to the nearest beat.
    len   = beats_q + 4'(cyc_q >= HALF_BEAT);
    split = (cyc_q == BEAT_LAST) && (beats_q == MAXB - 4'd1);

    case (state_q)
      S_IDLE: if (bus.rec_en) state_d = S_ARMED;
      S_ARMED: begin
        if (!bus.rec_en) state_d = S_IDLE;
        else if (stable_q != 5'd0) begin
          // Leading silence is skipped: recording starts on the first note.
          state_d = S_REC;
          cur_d   = stable_q;
          cyc_d   = '0;
          beats_d = '0;
        end
      end
      S_REC: begin
        if (!bus.rec_en) begin
          // Trailing rest is not worth storing.
          state_d    = S_IDLE;
          commit_req = (cur_q != 5'd0) && (len != 4'd0);
          commit_len = len;
        end else if (split) begin
          // Long note: emit a full-length entry and keep timing the same
          // note; a simultaneous note change rides on this single commit.
          commit_req = 1'b1;
          commit_len = MAXB;
          cyc_d      = '0;
          beats_d    = '0;
          cur_d      = stable_q;
        end else if (stable_q != cur_q) begin
          commit_req = (len != 4'd0);
          commit_len = len;
          cur_d      = stable_q;
          cyc_d      = '0;
          beats_d    = '0;
        end else if (cyc_q == BEAT_LAST) begin
          cyc_d   = '0;
          beats_d = beats_q + 4'd1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_FULL: if (!bus.rec_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Once the sheet is full, further commits are dropped silently.
    if (commit_req && count_q != FULL_CNT) begin
      we      = 1'b1;
      wdata   = {cur_q, commit_len};
      count_d = count_q + 1'b1;
      if (count_d == FULL_CNT && state_d == S_REC) state_d = S_FULL;
    end

    // Clear wins over any commit in the same cycle.
    if (bus.clear) begin
      we      = 1'b0;
      count_d = '0;
      state_d = bus.rec_en ? S_ARMED : S_IDLE;
    end

    // Outputs are derived from next-state values so they line up with state.
    cur_m1      = cur_d - 5'd1;
    led_idx     = 3'(cur_m1 % 5'd7);
    full_d      = (count_d == FULL_CNT);
    recording_d = (state_d == S_REC);
    led_d       = {full_d, 7'd0};
    if (state_d == S_REC && cur_d != 5'd0) led_d[6:0] = 7'd1 << led_idx;
  end

  // Control and status registers; the sheet read port is also registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      stab_cnt_q  <= '0;
      stable_q    <= '0;
      cur_q       <= '0;
      cyc_q       <= '0;
      beats_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      recording_q <= 1'b0;
      led_q       <= '0;
      rd_note_q   <= '0;
      rd_beats_q  <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      stable_q    <= stable_d;
      cur_q       <= cur_d;
      cyc_q       <= cyc_d;
      beats_q     <= beats_d;
      count_q     <= count_d;
      full_q      <= full_d;
      recording_q <= recording_d;
      led_q       <= led_d;
      rd_note_q   <= mem[bus.rd_addr][8:4];
      rd_beats_q  <= mem[bus.rd_addr][3:0];
    end
  end

  // Sheet memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[count_q[AW-1:0]] <= wdata;
  end

  assign bus.rd_note   = rd_note_q;
  assign bus.rd_beats  = rd_beats_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.recording = recording_q;
  assign bus.led       = led_q;
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with short beat/debounce timing and a
// four-entry sheet. Expected sheet contents are worked out by hand.
module tb_note_recorder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  note_recorder_if #(.DEPTH(4)) bus ();

  note_recorder #(
    .BEAT_CYC(10),
    .DEBOUNCE(3),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leave record mode, empty the sheet and let the stable note fall to 0.
  task automatic quiesce();
    bus.rec_en   = 1'b0;
    bus.key_note = 5'd0;
    bus.clear    = 1'b1;
    hold(1);
    bus.clear    = 1'b0;
    hold(6);
  endtask

  task automatic test_reset();
    bus.rec_en   = 1'b0;
    bus.clear    = 1'b0;
    bus.key_note = 5'd0;
    bus.rd_addr  = 2'd0;
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.full); end
    checks++; if (bus.recording !== 1'b0) begin errors++; $display("FAIL reset_recording got %0b exp 0", bus.recording); end
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_led got %b exp 00000000", bus.led); end
    checks++; if (bus.rd_note !== 5'd0 || bus.rd_beats !== 4'd0) begin errors++; $display("FAIL reset_rd got %0d/%0d exp 0/0", bus.rd_note, bus.rd_beats); end
  endtask

  task automatic test_basic();
    logic [8:0] exp_e [3];
    exp_e[0] = {5'd8, 4'd3};
    exp_e[1] = {5'd0, 4'd2};
    exp_e[2] = {5'd12, 4'd1};
    bus.rec_en   = 1'b1;
    bus.key_note = 5'd8;
    hold(15);
    checks++; if (bus.recording !== 1'b1) begin errors++; $display("FAIL basic_recording got %0b exp 1", bus.recording); end
    checks++; if (bus.led !== 8'b0000_0001) begin errors++; $display("FAIL basic_led8 got %b exp 00000001", bus.led); end
    hold(15);
    bus.key_note = 5'd0;
    hold(20);
    bus.key_note = 5'd12;
    hold(10);
    checks++; if (bus.led !== 8'b0001_0000) begin errors++; $display("FAIL basic_led12 got %b exp 00010000", bus.led); end
    bus.rec_en = 1'b0;
    hold(1);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
    checks++; if (bus.recording !== 1'b0) begin errors++; $display("FAIL basic_stop got %0b exp 0", bus.recording); end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 2'(i);
      hold(1);
      checks++;
      if ({bus.rd_note, bus.rd_beats} !== exp_e[i]) begin
        errors++;
        $display("FAIL basic_entry%0d got %0d/%0d exp %0d/%0d", i, bus.rd_note, bus.rd_beats, exp_e[i][8:4], exp_e[i][3:0]);
      end
    end
  endtask

  task automatic test_debounce_round();
    logic [8:0] exp_e [2];
    exp_e[0] = {5'd8, 4'd4};
    exp_e[1] = {5'd8, 4'd1};
    quiesce();
    // Glitch shorter than the debounce window must not split the note.
    bus.rec_en = 1'b1; bus.key_note = 5'd8; hold(20);
    bus.key_note = 5'd13; hold(2);
    bus.key_note = 5'd8;  hold(20);
    bus.rec_en = 1'b0; hold(1);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL glitch_count got %0d exp 1", bus.count); end
    bus.key_note = 5'd0; hold(6);
    // 13 counted cycles round down to one beat; the trailing rest is dropped.
    bus.rec_en = 1'b1; bus.key_note = 5'd8; hold(14);
    bus.key_note = 5'd0; hold(10);
    bus.rec_en = 1'b0; hold(7);
    // Too short to reach half a beat: dropped.
    bus.rec_en = 1'b1; bus.key_note = 5'd8; hold(4);
    bus.key_note = 5'd0; hold(10);
    bus.rec_en = 1'b0; hold(7);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL round_count got %0d exp 2", bus.count); end
    for (int i = 0; i < 2; i++) begin
      bus.rd_addr = 2'(i);
      hold(1);
      checks++;
      if ({bus.rd_note, bus.rd_beats} !== exp_e[i]) begin
        errors++;
        $display("FAIL round_entry%0d got %0d/%0d exp %0d/%0d", i, bus.rd_note, bus.rd_beats, exp_e[i][8:4], exp_e[i][3:0]);
      end
    end
  endtask

  task automatic test_long_split();
    logic [8:0] exp_e [2];
    exp_e[0] = {5'd10, 4'd15};
    exp_e[1] = {5'd10, 4'd2};
    quiesce();
    bus.rec_en = 1'b1; bus.key_note = 5'd10; hold(170);
    bus.rec_en = 1'b0; hold(1);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL split_count got %0d exp 2", bus.count); end
    for (int i = 0; i < 2; i++) begin
      bus.rd_addr = 2'(i);
      hold(1);
      checks++;
      if ({bus.rd_note, bus.rd_beats} !== exp_e[i]) begin
        errors++;
        $display("FAIL split_entry%0d got %0d/%0d exp %0d/%0d", i, bus.rd_note, bus.rd_beats, exp_e[i][8:4], exp_e[i][3:0]);
      end
    end
  endtask

  task automatic test_full_clear();
    quiesce();
    bus.rec_en = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      bus.key_note = 5'(n);
      hold(10);
    end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b exp 1", bus.full); end
    checks++; if (bus.led !== 8'h80) begin errors++; $display("FAIL full_led got %b exp 10000000", bus.led); end
    checks++; if (bus.recording !== 1'b0) begin errors++; $display("FAIL full_recording got %0b exp 0", bus.recording); end
    bus.rd_addr = 2'd3; hold(1);
    checks++; if ({bus.rd_note, bus.rd_beats} !== {5'd4, 4'd1}) begin errors++; $display("FAIL full_entry3 got %0d/%0d exp 4/1", bus.rd_note, bus.rd_beats); end
    bus.rd_addr = 2'd0; hold(1);
    checks++; if ({bus.rd_note, bus.rd_beats} !== {5'd1, 4'd1}) begin errors++; $display("FAIL full_entry0 got %0d/%0d exp 1/1", bus.rd_note, bus.rd_beats); end
    bus.clear = 1'b1; hold(1);
    bus.clear = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL clear_count got %0d/%0b exp 0/0", bus.count, bus.full); end
    checks++; if (bus.recording !== 1'b0) begin errors++; $display("FAIL clear_armed got %0b exp 0", bus.recording); end
    // From ARMED with note 6 already stable, REC is entered on the next edge.
    hold(1);
    checks++; if (bus.recording !== 1'b1) begin errors++; $display("FAIL clear_rearm got %0b exp 1", bus.recording); end
    checks++; if (bus.led !== 8'b0010_0000) begin errors++; $display("FAIL clear_led got %b exp 00100000", bus.led); end
  endtask

  task automatic test_reset_mid_rec();
    // Continues from the re-armed recording of note 6.
    hold(20);
    bus.key_note = 5'd9;
    hold(20);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL rst_pre_count got %0d exp 1", bus.count); end
    rst = 1'b1; bus.rec_en = 1'b0;
    hold(2);
    rst = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.recording !== 1'b0 || bus.led !== 8'h00) begin errors++; $display("FAIL rst_state got %0b/%b exp 0/00000000", bus.recording, bus.led); end
    bus.rd_addr = 2'd0; hold(1);
    checks++; if ({bus.rd_note, bus.rd_beats} !== {5'd6, 4'd2}) begin errors++; $display("FAIL rst_mem got %0d/%0d exp 6/2", bus.rd_note, bus.rd_beats); end
    hold(5);
    checks++; if (bus.count !== 3'd0 || bus.recording !== 1'b0) begin errors++; $display("FAIL rst_idle got %0d/%0b exp 0/0", bus.count, bus.recording); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_debounce_round();
    test_long_split();
    test_full_clear();
    test_reset_mid_rec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
